alu_addlogic_unit: RTL and testbench
====================================

Name: alu_addlogic_unit

Overview:
- Registered 32-bit arithmetic/logic slice for the single-cycle MIPS datapath ALU.
- Implements the three ALU primitives ADD, AND and NOR, selected by the standard 4-bit ALUControl code.
- Operands, opcode and valid are sampled on a clock edge; result and flags are presented one cycle later.
- SUB, SLT and SLL remain in separate blocks.

Parameters:
- WIDTH, 32, operand/result width in bits; flag semantics are defined relative to bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands and alu_control are valid this cycle.
- alu_control  input  4  operation select: 4'b0000 AND, 4'b0010 ADD, 4'b1100 NOR; all other codes are illegal.
- rs  input  WIDTH  operand A.
- rt  input  WIDTH  operand B; register value or sign-extended immediate.
- result  output  WIDTH  registered operation result.
- zero  output  1  registered; 1 when the registered result equals 0.
- carry_out  output  1  registered; unsigned carry out of bit WIDTH-1 (ADD only).
- overflow  output  1  registered; signed two's-complement overflow (ADD only).
- illegal_op  output  1  registered; 1 when the sampled alu_control is not a supported code.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset:
  - On a rising clk edge with rst_n=0, these outputs go to 0: result, zero, carry_out, overflow, illegal_op, out_valid.
  - Reset has priority over in_valid.
  - A reset mid-stream discards the in-flight operation; no out_valid is produced for that cycle's inputs.
- Latency and pipelining:
  - Exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear at edge N and are stable until the next update; out_valid=1 for that cycle.
  - Back-to-back operations are accepted every cycle. There is no backpressure.
- Idle cycles:
  - With in_valid=0, out_valid goes to 0.
  - result, zero, carry_out, overflow and illegal_op hold their last values.
- ADD:
  - result = (rs + rt) mod 2^WIDTH.
  - carry_out = bit WIDTH of the unsigned sum.
  - overflow = 1 iff rs[WIDTH-1]==rt[WIDTH-1] and result[WIDTH-1]!=rs[WIDTH-1].
  - Built from a ripple or carry-lookahead chain of 1-bit full adders with carry-in fixed at 0.
- AND:
  - result = rs & rt.
  - carry_out=0, overflow=0.
- NOR:
  - result = ~(rs | rt).
  - carry_out=0, overflow=0.
- Illegal code:
  - result=0, zero=1, carry_out=0, overflow=0, illegal_op=1.
  - illegal_op=0 for every legal code.
- zero flag:
  - Computed from the next-result value and registered in the same edge as result, so it never lags result.
- Width rules: all arithmetic is unsigned modulo 2^WIDTH. No sign extension happens inside the block.
- X handling: the opcode decode is a full case, so no latch is inferred and no X is generated for any defined alu_control value.

Test Plan:
- Reset:
  - Stimulus: drive rst_n=0 for 2 edges with in_valid=1, ADD 0x5+0x3.
  - Required: result=0, zero=0, carry_out=0, overflow=0, illegal_op=0, out_valid=0.
  - Stimulus: release rst_n.
  - Required: the next edge gives result=0x00000008, out_valid=1.
- ADD basic and wrap:
  - Stimulus: 0x00000005+0x00000003.
  - Required: result 0x00000008, zero=0, carry_out=0, overflow=0.
  - Stimulus (next cycle): 0xFFFFFFFF+0x00000001.
  - Required: result 0x00000000, zero=1, carry_out=1, overflow=0.
- ADD signed overflow:
  - Stimulus: 0x7FFFFFFF+0x00000001.
  - Required: result 0x80000000, overflow=1, carry_out=0.
  - Stimulus: 0x80000000+0x80000000.
  - Required: result 0, overflow=1, carry_out=1, zero=1.
- AND / NOR:
  - Stimulus: AND 0xF0F0F0F0, 0xFF00FF00.
  - Required: result 0xF000F000, zero=0.
  - Stimulus: NOR 0x0F0F0F0F, 0xF0F0F0F0.
  - Required: result 0x00000000, zero=1.
  - Stimulus: NOR 0, 0.
  - Required: result 0xFFFFFFFF.
  - All three cases are issued back-to-back, each visible exactly 1 cycle after issue.
- Illegal and idle:
  - Stimulus: alu_control=4'b0110 with rs=rt=0x12345678.
  - Required: result 0, zero=1, illegal_op=1.
  - Stimulus: hold in_valid=0 for 3 cycles.
  - Required: out_valid=0 and all other outputs unchanged.
- Reset mid-stream:
  - Stimulus: issue ADD 0x1+0x1, assert rst_n=0 on the same edge.
  - Required: result=0 and out_valid=0 on that edge, with no later out_valid for that operation.

Source files
------------

// File: rtl/alu_addlogic_unit.sv
// Registered ADD/AND/NOR slice of the MIPS datapath ALU.
// Result and flags appear one clock after the operands are sampled; idle cycles hold them.
module alu_addlogic_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal_op,
  output logic             out_valid
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_ADD = 4'b0010,
    OP_NOR = 4'b1100
  } alu_op_e;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // Ripple chain of 1-bit full adders, carry-in tied low.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]     = rs[i] ^ rt[i] ^ carry[i];
      carry[i+1] = (rs[i] & rt[i]) | (carry[i] & (rs[i] ^ rt[i]));
    end
  end

  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             next_overflow;
  logic             next_illegal;

  always_comb begin
    next_result   = '0;
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    next_illegal  = 1'b0;
    case (alu_control)
      OP_AND: next_result = rs & rt;
      OP_ADD: begin
        next_result   = sum;
        next_carry    = carry[WIDTH];
        next_overflow = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
      end
      OP_NOR: next_result = ~(rs | rt);
      default: next_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result     <= '0;
      zero       <= 1'b0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result     <= next_result;
        // Flag derived from the next result so it is updated on the same edge.
        zero       <= (next_result == '0);
        carry_out  <= next_carry;
        overflow   <= next_overflow;
        illegal_op <= next_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_addlogic_unit.sv
// Self-checking bench for alu_addlogic_unit: directed corner cases then randomized traffic
// compared against an arithmetic reference model.
module tb_alu_addlogic_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  alu_control;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] result;
  logic        zero;
  logic        carry_out;
  logic        overflow;
  logic        illegal_op;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected registered state
  logic [31:0] exp_result   = '0;
  logic        exp_zero     = 1'b0;
  logic        exp_carry    = 1'b0;
  logic        exp_ovf      = 1'b0;
  logic        exp_ill      = 1'b0;
  logic        exp_valid    = 1'b0;

  alu_addlogic_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .alu_control (alu_control),
    .rs          (rs),
    .rt          (rt),
    .result      (result),
    .zero        (zero),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .illegal_op  (illegal_op),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic c, output logic o,
                          output logic ill);
    logic [32:0] wide;
    longint      ssum;
    r = '0; c = 1'b0; o = 1'b0; ill = 1'b0;
    if (op == 4'd2) begin
      wide = {1'b0, a} + {1'b0, b};
      r    = wide[31:0];
      c    = wide[32];
      ssum = longint'($signed(a)) + longint'($signed(b));
      o    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    end else if (op == 4'd0) begin
      r = a & b;
    end else if (op == 4'd12) begin
      r = ~(a | b);
    end else begin
      ill = 1'b1;
    end
  endtask

  // Apply inputs for one edge, advance the model, then check every output.
  task automatic cycle(input logic rstn, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, o, ill;
    rst_n = rstn; in_valid = v; alu_control = op; rs = a; rt = b;
    @(posedge clk);
    #1;
    if (!rstn) begin
      exp_result = '0; exp_zero = 1'b0; exp_carry = 1'b0;
      exp_ovf = 1'b0; exp_ill = 1'b0; exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        model_op(op, a, b, r, c, o, ill);
        exp_result = r; exp_zero = (r == 32'd0); exp_carry = c;
        exp_ovf = o; exp_ill = ill;
      end
    end
    check("result",     result,            exp_result);
    check("zero",       {31'd0, zero},      {31'd0, exp_zero});
    check("carry_out",  {31'd0, carry_out}, {31'd0, exp_carry});
    check("overflow",   {31'd0, overflow},  {31'd0, exp_ovf});
    check("illegal_op", {31'd0, illegal_op},{31'd0, exp_ill});
    check("out_valid",  {31'd0, out_valid}, {31'd0, exp_valid});
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        v, rn;

    // Reset held over two edges with a valid ADD pending
    cycle(1'b0, 1'b1, 4'b0010, 32'h5, 32'h3);
    cycle(1'b0, 1'b1, 4'b0010, 32'h5, 32'h3);
    check("rst_result_const", result, 32'h0);
    cycle(1'b1, 1'b1, 4'b0010, 32'h5, 32'h3);
    check("post_rst_add", result, 32'h8);

    // ADD wrap and signed overflow
    cycle(1'b1, 1'b1, 4'b0010, 32'hFFFFFFFF, 32'h1);
    check("wrap_carry", {31'd0, carry_out}, 32'd1);
    cycle(1'b1, 1'b1, 4'b0010, 32'h7FFFFFFF, 32'h1);
    check("ovf_pos", {31'd0, overflow}, 32'd1);
    cycle(1'b1, 1'b1, 4'b0010, 32'h80000000, 32'h80000000);
    check("ovf_neg_zero", {31'd0, zero}, 32'd1);

    // Logic ops back-to-back
    cycle(1'b1, 1'b1, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
    check("and_val", result, 32'hF000F000);
    cycle(1'b1, 1'b1, 4'b1100, 32'h0F0F0F0F, 32'hF0F0F0F0);
    check("nor_zero", result, 32'h0);
    cycle(1'b1, 1'b1, 4'b1100, 32'h0, 32'h0);
    check("nor_ones", result, 32'hFFFFFFFF);

    // Illegal code then idle hold
    cycle(1'b1, 1'b1, 4'b0110, 32'h12345678, 32'h12345678);
    check("illegal_flag", {31'd0, illegal_op}, 32'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 4'b0010, $urandom, $urandom);

    // Reset on the same edge as an issued ADD
    cycle(1'b1, 1'b1, 4'b0010, 32'h10, 32'h20);
    cycle(1'b0, 1'b1, 4'b0010, 32'h1, 32'h1);
    cycle(1'b1, 1'b0, 4'b0010, 32'h1, 32'h1);
    check("mid_rst_novalid", {31'd0, out_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: op = 4'b0000;
        1, 2: op = 4'b0010;
        3: op = 4'b1100;
        default: op = 4'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: a = 32'hFFFFFFFF;
        1: a = 32'h80000000;
        2: a = 32'h7FFFFFFF;
        default: a = $urandom;
      endcase
      b  = ($urandom_range(0, 5) == 0) ? ~a : 32'($urandom);
      v  = ($urandom_range(0, 4) != 0);
      rn = ($urandom_range(0, 30) != 0);
      cycle(rn, v, op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
